serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial addition controller. One gate-level full adder cell adds two WIDTH-bit operands, one bit per clock, LSB first. The block holds the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. It is the sequencer that lets a single full adder serve as a multi-bit adder in area-constrained designs.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request: begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
cin  input  1  carry-in; captured on the accepted start edge
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result register; holds the last completed sum
cout  output  1  carry-out of the last completed addition
ovf  output  1  two's-complement overflow of the last completed addition

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, asynchronous, no clock needed): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0. Shift registers, carry flip-flop and counter all clear to 0.
- States: IDLE, RUN, DONE. Encoding is held in the shared package.
- IDLE:
  - start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, res_sh<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, every edge:
  - Full adder inputs: a_sh[0], b_sh[0], carry.
  - Shift the full adder sum bit into res_sh at the MSB (res_sh shifts right).
  - carry<=full adder carry. a_sh and b_sh shift right by one. cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1:
    - sum<=final res_sh value, including this bit.
    - cout<=final carry-out.
    - ovf<=carry into the MSB XOR final carry-out; the carry into the MSB is the carry register value in this cycle.
    - Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency:
  - start sampled at edge E0; done is high in the cycle after edge E0+WIDTH.
  - sum, cout and ovf update at that same edge.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- busy=1 in RUN and DONE; busy=0 in IDLE.
- start while busy (RUN or DONE) is ignored: not queued, and operands are not re-captured.
- start high in the first IDLE cycle after DONE is accepted, so back-to-back operations work.
- sum, cout and ovf hold their values through IDLE and through the next RUN. They change only at a completion edge, never mid-run.
- a, b and cin may change freely after capture without affecting the operation in flight.
- All arithmetic is modulo 2^WIDTH; cout carries the (WIDTH+1)th bit.
- Reset mid-RUN aborts the operation: no done pulse, and outputs clear as above.
- done and busy are registered state decodes. Outputs are glitch-free.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH.
- Sub-module: the existing gate-level fulladder cell, instantiated once; port order (sum, carry, a, b, c).
- All other logic (FSM, counter, shift registers, carry flip-flop) lives in serial_add_ctrl.

Test Plan:
1. Reset: rst_n=0 with clk running and start=1 -> busy=0, done=0, sum=8'h00, cout=0, ovf=0; no transition while reset is held.
2. a=8'h0F, b=8'h01, cin=0, start pulse at E0 -> busy high from E0, done pulse after E0+8, sum=8'h10, cout=0, ovf=0.
3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
4. Start a=8'h12, b=8'h34. In RUN, pulse start again with a=8'hFF, b=8'hFF -> ignored, sum=8'h46, exactly one done pulse. Then start in the first IDLE cycle after done -> accepted.
5. Assert rst_n=0 asynchronously mid-RUN (after 4 bit cycles) -> outputs clear immediately, no done. After release, start a=8'h01, b=8'h01 -> sum=8'h02.
6. WIDTH=4 exhaustive: all 512 (a, b, cin) combinations, back-to-back -> {cout, sum}==a+b+cin, and ovf matches the signed-overflow reference every time.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default width.
package serial_add_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fulladder.sv
// Gate-level full adder cell shared by the serial adder datapath.
module fulladder (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c
);

  logic ab_x;
  logic ab_a;
  logic abc_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (sum, ab_x, c);
  and g_a1 (ab_a, a, b);
  and g_a2 (abc_a, ab_x, c);
  or  g_o1 (carry, ab_a, abc_a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition sequencer: feeds one full adder LSB-first over WIDTH cycles
// and publishes sum/cout/ovf with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] res_next;

  fulladder u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q)
  );

  assign res_next = {fa_sum, res_sh_q[WIDTH-1:1]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          res_sh_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = res_next;
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        // carry_q here is the carry into the MSB on the final bit
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_next;
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: 8-bit hand-computed vectors plus an
// exhaustive 4-bit sweep against an arithmetic reference.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_sum8;
  int done_cnt;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation: start on a negedge, wait for done with a bound.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv; cin8 = ~ci;
    chk({tag, " busy"}, 64'(busy8), 64'(1));
    n = 0;
    while (!done8 && n < 20) begin
      if (n == 4) chk({tag, " sum_hold"}, 64'(sum8), 64'(prev_sum8));
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(8));
    chk({tag, " done"}, 64'(done8), 64'(1));
    chk({tag, " sum"}, 64'(sum8), 64'(es));
    chk({tag, " cout"}, 64'(cout8), 64'(ec));
    chk({tag, " ovf"}, 64'(ovf8), 64'(eo));
    prev_sum8 = es;
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    prev_sum8 = 8'h00;

    // Reset held with start asserted: nothing moves
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst busy", 64'(busy8), 64'(0));
      chk("rst done", 64'(done8), 64'(0));
    end
    chk("rst sum", 64'(sum8), 64'(8'h00));
    chk("rst cout", 64'(cout8), 64'(0));
    chk("rst ovf", 64'(ovf8), 64'(0));
    start8 = 1'b0;
    rst_n  = 1'b1;

    run8("t2 0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run8("t3 ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("t3 7f+00+1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    run8("t3 80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run8("t3 a5+5a+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

    // Start during RUN must be ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1; end
      if (i == 4) begin
        start8 = 1'b0;
        chk("t4 busy_ignored", 64'(busy8), 64'(1));
      end
      if (done8) done_cnt++;
      @(negedge clk);
    end
    chk("t4 one_done", 64'(done_cnt), 64'(1));
    chk("t4 sum", 64'(sum8), 64'(8'h46));
    chk("t4 idle", 64'(busy8), 64'(0));
    prev_sum8 = 8'h46;
    run8("t4 b2b_a", 8'h20, 8'h03, 1'b0, 8'h23, 1'b0, 1'b0);
    run8("t4 b2b_b", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 rst sum", 64'(sum8), 64'(8'h00));
    chk("t5 rst ovf", 64'(ovf8), 64'(0));
    chk("t5 rst busy", 64'(busy8), 64'(0));
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8) done_cnt++;
    end
    chk("t5 no_done", 64'(done_cnt), 64'(0));
    rst_n = 1'b1;
    prev_sum8 = 8'h00;
    run8("t5 01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep, back to back
    for (int i = 0; i < 512; i++) begin
      logic [3:0] av, bv;
      logic       ci;
      logic [4:0] full;
      logic       eo;
      int         n;
      av = 4'(i);
      bv = 4'(i >> 4);
      ci = 1'(i >> 8);
      full = 5'(av) + 5'(bv) + 5'(ci);
      eo = (av[3] == bv[3]) && (full[3] != av[3]);
      @(negedge clk);
      a4 = av; b4 = bv; cin4 = ci; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      a4 = ~av; b4 = ~bv;
      n = 0;
      while (!done4 && n < 12) begin
        @(negedge clk);
        n++;
      end
      chk("w4 done", 64'(done4), 64'(1));
      chk("w4 latency", 64'(n), 64'(4));
      chk("w4 sum_cout", 64'({cout4, sum4}), 64'(full));
      chk("w4 ovf", 64'(ovf4), 64'(eo));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
